// File: rtl/mem_line_server.sv
// Cache-line server: writes back evicted 16-word dirty lines and fills data/instruction
// lines from a single-port word memory, one request at a time (evict > data > instr).
module mem_line_server #(
    parameter int LINE_WORDS = 16,
    parameter int MEM_AW     = 13
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cacheMissFetch,
    input  logic [31:0]                instrAddr,
    input  logic                       cacheMissMemory,
    input  logic [31:0]                aluResult,
    input  logic                       dCacheEvict,
    input  logic [31:0]                evictAddr,
    input  logic [32*LINE_WORDS-1:0]   dCacheOut,
    input  logic [31:0]                memRdData,
    output logic [MEM_AW-1:0]          memAddr,
    output logic                       memRdEn,
    output logic                       memWrEn,
    output logic [31:0]                memWrData,
    output logic [32*LINE_WORDS-1:0]   mcInstrIn,
    output logic                       mcInstrValid,
    output logic [32*LINE_WORDS-1:0]   mcDataIn,
    output logic                       mcDataValid,
    output logic                       evictDone,
    output logic                       busy
);
    localparam int LW = 32 * LINE_WORDS;

    typedef enum logic [2:0] {IDLE, EVICT, DFILL, IFILL, RESP} state_t;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [MEM_AW-1:0]   base_q, base_d;
    logic [LW-1:0]       line_q, line_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic                mem_wr_en_q, mem_wr_en_d;
    logic [31:0]         mem_wr_data_q, mem_wr_data_d;
    logic [LW-1:0]       mc_instr_in_q, mc_instr_in_d;
    logic                mc_instr_valid_q, mc_instr_valid_d;
    logic [LW-1:0]       mc_data_in_q, mc_data_in_d;
    logic                mc_data_valid_q, mc_data_valid_d;
    logic                evict_done_q, evict_done_d;
    logic                busy_q, busy_d;
    logic [3:0]          nxt_idx;
    logic [3:0]          cap_idx;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{instrAddr[31:MEM_AW], instrAddr[3:0],
                                aluResult[31:MEM_AW], aluResult[3:0],
                                evictAddr[31:MEM_AW], evictAddr[3:0]};

    // Next-state and next-output logic; cnt counts cycles since acceptance (cnt = j-1 in cycle T+j)
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        base_d           = base_q;
        line_d           = line_q;
        mem_addr_d       = '0;
        mem_rd_en_d      = 1'b0;
        mem_wr_en_d      = 1'b0;
        mem_wr_data_d    = 32'h0000_0000;
        mc_instr_in_d    = mc_instr_in_q;
        mc_instr_valid_d = 1'b0;
        mc_data_in_d     = mc_data_in_q;
        mc_data_valid_d  = 1'b0;
        evict_done_d     = 1'b0;
        nxt_idx          = cnt_q[3:0] + 4'd1;
        cap_idx          = cnt_q[3:0] - 4'd1;
        case (state_q)
            IDLE: begin
                cnt_d = 5'd0;
                if (dCacheEvict) begin
                    state_d       = EVICT;
                    base_d        = {evictAddr[MEM_AW-1:4], 4'b0000};
                    line_d        = dCacheOut;
                    mem_wr_en_d   = 1'b1;
                    mem_addr_d    = base_d;
                    mem_wr_data_d = dCacheOut[31:0];
                end else if (cacheMissMemory) begin
                    state_d     = DFILL;
                    base_d      = {aluResult[MEM_AW-1:4], 4'b0000};
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = base_d;
                end else if (cacheMissFetch) begin
                    state_d     = IFILL;
                    base_d      = {instrAddr[MEM_AW-1:4], 4'b0000};
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = base_d;
                end else begin
                    state_d = IDLE;
                end
            end
            EVICT: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q < 5'd15) begin
                    mem_wr_en_d   = 1'b1;
                    mem_addr_d    = base_q + MEM_AW'(nxt_idx);
                    mem_wr_data_d = line_q[{nxt_idx, 5'b00000} +: 32];
                end else if (cnt_q == 5'd15) begin
                    evict_done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end
            end
            DFILL, IFILL: begin
                cnt_d = cnt_q + 5'd1;
                // Read data lags its strobe by one cycle, so word k lands while cnt = k+1
                if (cnt_q != 5'd0) begin
                    line_d[{cap_idx, 5'b00000} +: 32] = memRdData;
                end else begin
                    line_d = line_q;
                end
                if (cnt_q < 5'd15) begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = base_q + MEM_AW'(nxt_idx);
                end else if (cnt_q == 5'd16) begin
                    state_d = RESP;
                    cnt_d   = 5'd0;
                    if (state_q == IFILL) begin
                        mc_instr_in_d    = line_d;
                        mc_instr_valid_d = 1'b1;
                    end else begin
                        mc_data_in_d    = line_d;
                        mc_data_valid_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= 5'd0;
            base_q           <= '0;
            line_q           <= '0;
            mem_addr_q       <= '0;
            mem_rd_en_q      <= 1'b0;
            mem_wr_en_q      <= 1'b0;
            mem_wr_data_q    <= 32'h0000_0000;
            mc_instr_in_q    <= '0;
            mc_instr_valid_q <= 1'b0;
            mc_data_in_q     <= '0;
            mc_data_valid_q  <= 1'b0;
            evict_done_q     <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            base_q           <= base_d;
            line_q           <= line_d;
            mem_addr_q       <= mem_addr_d;
            mem_rd_en_q      <= mem_rd_en_d;
            mem_wr_en_q      <= mem_wr_en_d;
            mem_wr_data_q    <= mem_wr_data_d;
            mc_instr_in_q    <= mc_instr_in_d;
            mc_instr_valid_q <= mc_instr_valid_d;
            mc_data_in_q     <= mc_data_in_d;
            mc_data_valid_q  <= mc_data_valid_d;
            evict_done_q     <= evict_done_d;
            busy_q           <= busy_d;
        end
    end

    assign memAddr      = mem_addr_q;
    assign memRdEn      = mem_rd_en_q;
    assign memWrEn      = mem_wr_en_q;
    assign memWrData    = mem_wr_data_q;
    assign mcInstrIn    = mc_instr_in_q;
    assign mcInstrValid = mc_instr_valid_q;
    assign mcDataIn     = mc_data_in_q;
    assign mcDataValid  = mc_data_valid_q;
    assign evictDone    = evict_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mem_line_server.sv
// Scoreboard bench for mem_line_server: a line-level reference model queues the expected
// memory accesses and responses; a negedge monitor pops and compares whatever the DUT shows.
module tb_mem_line_server;
    logic         clk = 1'b0;
    logic         rst;
    logic         cacheMissFetch, cacheMissMemory, dCacheEvict;
    logic [31:0]  instrAddr, aluResult, evictAddr, memRdData;
    logic [511:0] dCacheOut;
    logic [12:0]  memAddr;
    logic         memRdEn, memWrEn, mcInstrValid, mcDataValid, evictDone, busy;
    logic [31:0]  memWrData;
    logic [511:0] mcInstrIn, mcDataIn;

    always #5 clk = ~clk;

    mem_line_server dut (
        .clk(clk), .rst(rst),
        .cacheMissFetch(cacheMissFetch), .instrAddr(instrAddr),
        .cacheMissMemory(cacheMissMemory), .aluResult(aluResult),
        .dCacheEvict(dCacheEvict), .evictAddr(evictAddr), .dCacheOut(dCacheOut),
        .memRdData(memRdData), .memAddr(memAddr), .memRdEn(memRdEn), .memWrEn(memWrEn),
        .memWrData(memWrData), .mcInstrIn(mcInstrIn), .mcInstrValid(mcInstrValid),
        .mcDataIn(mcDataIn), .mcDataValid(mcDataValid), .evictDone(evictDone), .busy(busy)
    );

    // Backing memory seen by the DUT
    logic [31:0] mem [0:8191];
    logic        init_mem;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 32'hA000_0000 + i;
            memRdData <= 32'h0;
        end else begin
            if (memWrEn) mem[memAddr] <= memWrData;
            memRdData <= memRdEn ? mem[memAddr] : 32'h0;
        end
    end

    typedef struct {
        bit          wr;
        logic [12:0] addr;
        logic [31:0] data;
        int          k;
    } acc_t;
    typedef struct {
        int           kind;   // 0 evict, 1 data fill, 2 instr fill
        logic [511:0] line;
    } rsp_t;

    acc_t        exp_acc[$];
    rsp_t        exp_rsp[$];
    logic [31:0] ref_mem [0:8191];
    int          checks = 0;
    int          errors = 0;
    int          timeouts = 0;
    int          cyc = 0;
    bit          chk_zero = 1'b0;
    bit          final_check = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a request becomes 16 word accesses on an aligned, wrapping line
    task automatic model_evict(input logic [31:0] a, input logic [511:0] l);
        acc_t        e;
        rsp_t        r;
        logic [12:0] b;
        b = a[12:0] & 13'h1FF0;
        for (int k = 0; k < 16; k++) begin
            e.wr = 1'b1; e.addr = b + 13'(k); e.data = l[32*k +: 32]; e.k = k;
            exp_acc.push_back(e);
            ref_mem[e.addr] = e.data;
        end
        r.kind = 0; r.line = '0;
        exp_rsp.push_back(r);
    endtask

    task automatic model_fill(input int kind, input logic [31:0] a);
        acc_t        e;
        rsp_t        r;
        logic [12:0] b;
        b = a[12:0] & 13'h1FF0;
        r.kind = kind; r.line = '0;
        for (int k = 0; k < 16; k++) begin
            e.wr = 1'b0; e.addr = b + 13'(k); e.data = ref_mem[e.addr]; e.k = k;
            exp_acc.push_back(e);
            r.line[32*k +: 32] = e.data;
        end
        exp_rsp.push_back(r);
    endtask

    // Monitor: compares every strobe and pulse against the scoreboard queues
    acc_t         m_acc;
    rsp_t         m_rsp;
    logic [511:0] last_i = '0;
    logic [511:0] last_d = '0;
    int           start_cyc = 0;
    int           npulse, kind_got, lat;
    always @(negedge clk) begin
        if (rst) begin
            last_i = '0;
            last_d = '0;
        end
        if (chk_zero) begin
            checks++;
            if ({memRdEn, memWrEn, evictDone, mcInstrValid, mcDataValid, busy} !== 6'b0 ||
                mcInstrIn !== '0 || mcDataIn !== '0) begin
                errors++;
                $display("FAIL reset_zero ctl=%b instr=%h data=%h required all zero",
                         {memRdEn, memWrEn, evictDone, mcInstrValid, mcDataValid, busy}, mcInstrIn, mcDataIn);
            end
        end
        if (memRdEn || memWrEn) begin
            checks++;
            if (memRdEn && memWrEn) begin
                errors++;
                $display("FAIL strobe_overlap rd=1 wr=1 required at most one");
            end else if (exp_acc.size() == 0) begin
                errors++;
                $display("FAIL unexpected_access wr=%0b addr=%h required no access", memWrEn, memAddr);
            end else begin
                m_acc = exp_acc.pop_front();
                if (memWrEn !== m_acc.wr || memAddr !== m_acc.addr || (m_acc.wr && memWrData !== m_acc.data)) begin
                    errors++;
                    $display("FAIL access k=%0d got wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h",
                             m_acc.k, memWrEn, memAddr, memWrData, m_acc.wr, m_acc.addr, m_acc.data);
                end
                if (m_acc.k == 0) start_cyc = cyc;
            end
        end
        npulse = int'(evictDone) + int'(mcDataValid) + int'(mcInstrValid);
        if (npulse != 0) begin
            checks++;
            if (npulse > 1 || exp_rsp.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse ev=%0b dv=%0b iv=%0b pending=%0d",
                         evictDone, mcDataValid, mcInstrValid, exp_rsp.size());
            end else begin
                m_rsp = exp_rsp.pop_front();
                kind_got = evictDone ? 0 : (mcDataValid ? 1 : 2);
                if (kind_got != m_rsp.kind) begin
                    errors++;
                    $display("FAIL rsp_kind got %0d required %0d", kind_got, m_rsp.kind);
                end else if (m_rsp.kind == 1 && (mcDataIn !== m_rsp.line || mcInstrIn !== last_i)) begin
                    errors++;
                    $display("FAIL data_line got %h required %h", mcDataIn, m_rsp.line);
                end else if (m_rsp.kind == 2 && (mcInstrIn !== m_rsp.line || mcDataIn !== last_d)) begin
                    errors++;
                    $display("FAIL instr_line got %h required %h", mcInstrIn, m_rsp.line);
                end
                checks++;
                lat = cyc - start_cyc;
                if (lat != ((m_rsp.kind == 0) ? 16 : 17)) begin
                    errors++;
                    $display("FAIL pulse_timing kind=%0d got %0d cycles after first access required %0d",
                             m_rsp.kind, lat, (m_rsp.kind == 0) ? 16 : 17);
                end
                if (m_rsp.kind == 1) last_d = m_rsp.line;
                if (m_rsp.kind == 2) last_i = m_rsp.line;
            end
        end
        if (final_check) begin
            checks++;
            if (exp_acc.size() != 0 || exp_rsp.size() != 0 || timeouts != 0) begin
                errors++;
                $display("FAIL drain acc=%0d rsp=%0d timeouts=%0d required 0 0 0",
                         exp_acc.size(), exp_rsp.size(), timeouts);
            end
        end
    end

    // Raise a set of requests together and hold each until its completion pulse
    task automatic issue(input bit e, input bit d, input bit i,
                         input logic [31:0] ea, input logic [31:0] da, input logic [31:0] ia,
                         input logic [511:0] eline);
        int n, got;
        if (e) model_evict(ea, eline);
        if (d) model_fill(1, da);
        if (i) model_fill(2, ia);
        @(negedge clk);
        dCacheEvict = e; evictAddr = ea; dCacheOut = eline;
        cacheMissMemory = d; aluResult = da;
        cacheMissFetch = i; instrAddr = ia;
        n = int'(e) + int'(d) + int'(i);
        got = 0;
        for (int c = 0; c < 300 && got < n; c++) begin
            @(negedge clk);
            if (c == 2) begin
                if (e) begin evictAddr = 32'h0; dCacheOut = ~eline; end
                else if (d) aluResult = 32'h0;
                else instrAddr = 32'h0;
            end
            if (evictDone)    begin dCacheEvict = 1'b0;     got++; end
            if (mcDataValid)  begin cacheMissMemory = 1'b0; got++; end
            if (mcInstrValid) begin cacheMissFetch = 1'b0;  got++; end
        end
        if (got < n) begin
            timeouts++;
            dCacheEvict = 1'b0; cacheMissMemory = 1'b0; cacheMissFetch = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic rand_line(output logic [511:0] l);
        for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
    endtask

    logic [511:0] line_v;
    acc_t         acc_v;
    initial begin
        rst = 1'b1; init_mem = 1'b1;
        cacheMissFetch = 1'b0; cacheMissMemory = 1'b0; dCacheEvict = 1'b0;
        instrAddr = 32'h0; aluResult = 32'h0; evictAddr = 32'h0; dCacheOut = '0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = 32'hA000_0000 + i;
        @(posedge clk); #1 chk_zero = 1'b1;
        @(posedge clk); #1 chk_zero = 1'b0;
        @(negedge clk); rst = 1'b0; init_mem = 1'b0;

        issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0025, '0);
        for (int k = 0; k < 16; k++) line_v[32*k +: 32] = 32'h5500_0000 + k;
        issue(1'b1, 1'b0, 1'b0, 32'h0000_0108, 32'h0, 32'h0, line_v);
        issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0100, '0);
        rand_line(line_v);
        issue(1'b1, 1'b1, 1'b1, 32'h0000_0A3C, 32'h0000_0A31, 32'h0000_0B07, line_v);
        issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_1FF8, 32'h0, '0);
        issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFF5, '0);

        // Data fill aborted by reset in cycle T+8: eight reads, then nothing
        @(negedge clk);
        cacheMissMemory = 1'b1; aluResult = 32'h0000_0345;
        for (int k = 0; k < 8; k++) begin
            acc_v.wr = 1'b0; acc_v.addr = 13'h0340 + 13'(k); acc_v.data = ref_mem[acc_v.addr]; acc_v.k = k;
            exp_acc.push_back(acc_v);
        end
        @(posedge clk);
        repeat (7) @(posedge clk);
        @(negedge clk); rst = 1'b1; cacheMissMemory = 1'b0;
        @(posedge clk); #1 chk_zero = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1 chk_zero = 1'b0;
        issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0347, '0);

        for (int t = 0; t < 40; t++) begin
            bit e, d, i;
            e = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            i = 1'($urandom_range(0, 1));
            if (!(e || d || i)) d = 1'b1;
            rand_line(line_v);
            issue(e, d, i, $urandom, $urandom, $urandom, line_v);
        end

        @(posedge clk); #1 final_check = 1'b1;
        @(posedge clk); #1 final_check = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_line_server.md
MEM_LINE_SERVER -- requirements
Module: mem_line_server

Interface
REQ-001 Parameter LINE_WORDS, default 16, meaning 32-bit words per cache line (fixed at 16; the 512-bit line width depends on it).
REQ-002 Parameter MEM_AW, default 13, meaning backing-memory word-address width (8192 words).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cacheMissFetch  input  1  instruction-line fill request, held high until mcInstrValid.
REQ-006 instrAddr  input  32  word address of the missing instruction.
REQ-007 cacheMissMemory  input  1  data-line fill request, held high until mcDataValid.
REQ-008 aluResult  input  32  word address of the missing data.
REQ-009 dCacheEvict  input  1  dirty-line writeback request, held high until evictDone.
REQ-010 evictAddr  input  32  word address inside the line being evicted.
REQ-011 dCacheOut  input  512  evicted line; word k occupies bits [32k+31:32k].
REQ-012 memRdData  input  32  backing-memory read data, valid one cycle after memRdEn.
REQ-013 memAddr  output  MEM_AW  backing-memory word address.
REQ-014 memRdEn  output  1  memory read strobe.
REQ-015 memWrEn  output  1  memory write strobe.
REQ-016 memWrData  output  32  memory write data.
REQ-017 mcInstrIn  output  512  filled instruction line; word k in bits [32k+31:32k].
REQ-018 mcInstrValid  output  1  one-cycle pulse; mcInstrIn is valid.
REQ-019 mcDataIn  output  512  filled data line, same packing.
REQ-020 mcDataValid  output  1  one-cycle pulse; mcDataIn is valid.
REQ-021 evictDone  output  1  one-cycle pulse; writeback complete.
REQ-022 busy  output  1  high in every state except IDLE.

Function
REQ-023 States SHALL be IDLE, EVICT, DFILL, IFILL, RESP; one request is serviced at a time.
REQ-024 In IDLE, priority SHALL be dCacheEvict > cacheMissMemory > cacheMissFetch; unselected requests stay pending.
REQ-025 On acceptance, line base = request address with bits [3:0] cleared, truncated to MEM_AW bits, is latched; later changes to address or data inputs are ignored.
REQ-026 On eviction acceptance, dCacheOut SHALL be latched in the same cycle.
REQ-027 EVICT: cycles T+1..T+16 (T = accept cycle) assert memWrEn with memAddr = base+k and memWrData = word k, k = 0..15 ascending.
REQ-028 EVICT: evictDone SHALL pulse in cycle T+17, followed by a return to IDLE.
REQ-029 FILL: cycles T+1..T+16 assert memRdEn with memAddr = base+k, k = 0..15; memRdData returned in cycle T+k+2 is written into word k.
REQ-030 FILL: the line register SHALL update with all 16 words, and the matching valid signal SHALL pulse high for exactly cycle T+18 (RESP), followed by a return to IDLE.
REQ-031 A fill updates only its own line output; mcInstrIn and mcDataIn hold their last value between fills.
REQ-032 memRdEn and memWrEn SHALL never be high in the same cycle; memAddr and memWrData are don't-care while both are low.
REQ-033 Address arithmetic base+k SHALL wrap modulo 2^MEM_AW.
REQ-034 A request still high in the cycle after its completion pulse SHALL be treated as a new request.
REQ-035 Simultaneous eviction and data miss: the eviction completes first, then the data fill starts from IDLE (back-to-back writeback/refill).

Reset
REQ-036 While rst is high at posedge, state SHALL be IDLE and all outputs zero, including mcInstrIn and mcDataIn.
REQ-037 rst mid-operation SHALL abort immediately with no completion pulse and no further memory accesses; pending requests are re-sampled afresh after reset.

Verification
REQ-038 Memory word i = 0xA000_0000+i, fetch at instrAddr 0x25 -> reads 0x20..0x2F; mcInstrValid at T+18 only; mcInstrIn[31:0]=0xA0000020, [511:480]=0xA000002F.
REQ-039 Eviction at evictAddr 0x108 with word k = 0x5500_0000+k -> writes to 0x100..0x10F ascending; evictDone at T+17; readback of memory matches.
REQ-040 dCacheEvict, cacheMissMemory and cacheMissFetch asserted together -> service order evict, data fill, instruction fill; each pulse occurs once; no strobe overlap.
REQ-041 Fill at address 0x1FF8 -> addresses 0x1FF0..0x1FFF; fill at 0xFFFF_FFF5 -> addresses 0x1FF0..0x1FFF (truncation); instrAddr changed to 0x0 at T+3 has no effect.
REQ-042 rst asserted at T+8 of a data fill -> no mcDataValid; outputs zero; busy 0; a following fetch completes normally in 18 cycles.
